z80_mem_ctl: RTL and testbench

Synchronous memory-bus controller between the A-Z80 CPU pins and the asynchronous SRAM (active-low CS/WE/OE, 16-bit address, bidirectional 8-bit data). It samples Z80 memory cycles on CLK, generates glitch-free RAM strobes with programmable access time, and stretches CPU cycles through nWAIT. It also latches read data for the CPU, filters refresh cycles, and counts bus-protocol violations for the testbench.

---
 rtl/z80_mem_ctl_if.sv | 30 +++
 rtl/z80_mem_ctl.sv | 197 +++++++++++++++++++
 tb/tb_z80_mem_ctl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/z80_mem_ctl_if.sv
// Bus bundle between the Z80 CPU pins and the SRAM controller (everything except
// clock, reset and the bidirectional RAM data bus).
`timescale 1ns/1ps
interface z80_mem_ctl_if;
  logic [15:0] A;
  logic [7:0]  D_in;
  logic [7:0]  D_out;
  logic        D_oe;
  logic        nMREQ;
  logic        nRD;
  logic        nWR;
  logic        nRFSH;
  logic        nWAIT;
  logic [15:0] ram_A;
  logic        ram_nCS;
  logic        ram_nOE;
  logic        ram_nWE;
  logic [7:0]  err_cnt;

  // CPU side (and the bench) drives the strobes, the controller answers.
  modport master (
    output A, D_in, nMREQ, nRD, nWR, nRFSH,
    input  D_out, D_oe, nWAIT, ram_A, ram_nCS, ram_nOE, ram_nWE, err_cnt
  );

  modport slave (
    input  A, D_in, nMREQ, nRD, nWR, nRFSH,
    output D_out, D_oe, nWAIT, ram_A, ram_nCS, ram_nOE, ram_nWE, err_cnt
  );
endinterface

// File: rtl/z80_mem_ctl.sv
// Z80-to-async-SRAM controller: registered RAM strobes with programmable access
// and write-pulse width, CPU stretching through nWAIT, refresh filtering.
`timescale 1ns/1ps
module z80_mem_ctl #(
  parameter int unsigned WAIT_RD = 1,
  parameter int unsigned WAIT_WR = 1
) (
  input  logic          CLK,
  input  logic          nRESET,
  z80_mem_ctl_if.slave  bus,
  inout  wire [7:0]     ram_D
);

  localparam logic [3:0] WAIT_RD_C = WAIT_RD[3:0];
  localparam logic [3:0] WAIT_WR_C = WAIT_WR[3:0];

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    RD_HOLD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] ram_a_q, ram_a_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wdrv_q, wdrv_d;
  logic        ncs_q, ncs_d;
  logic        noe_q, noe_d;
  logic        nwe_q, nwe_d;
  logic        nwait_q, nwait_d;
  logic [7:0]  dout_q, dout_d;
  logic        doe_q, doe_d;
  logic [7:0]  err_q, err_d;

  logic rd_req;
  logic wr_req;
  logic bus_err;

  // Refresh cycles carry nMREQ low too; they must never reach the RAM.
  assign rd_req  = !bus.nMREQ && bus.nRFSH && !bus.nRD && bus.nWR;
  assign wr_req  = !bus.nMREQ && bus.nRFSH && !bus.nWR && bus.nRD;
  assign bus_err = !bus.nMREQ && !bus.nRD && !bus.nWR;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ram_a_d = ram_a_q;
    wdata_d = wdata_q;
    wdrv_d  = wdrv_q;
    ncs_d   = ncs_q;
    noe_d   = noe_q;
    nwe_d   = nwe_q;
    nwait_d = nwait_q;
    dout_d  = dout_q;
    doe_d   = doe_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (rd_req) begin
          ram_a_d = bus.A;
          ncs_d   = 1'b0;
          noe_d   = 1'b0;
          cnt_d   = WAIT_RD_C;
          nwait_d = 1'b0;
          state_d = RD_ACC;
        end else if (wr_req) begin
          // nWE stays high this edge so address and data settle before the pulse.
          ram_a_d = bus.A;
          wdata_d = bus.D_in;
          wdrv_d  = 1'b1;
          ncs_d   = 1'b0;
          nwait_d = 1'b0;
          state_d = WR_SETUP;
        end else if (bus_err && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
      end

      RD_ACC: begin
        if (bus.nMREQ) begin
          ncs_d   = 1'b1;
          noe_d   = 1'b1;
          nwait_d = 1'b1;
          doe_d   = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          dout_d  = ram_D;
          doe_d   = 1'b1;
          nwait_d = 1'b1;
          state_d = RD_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RD_HOLD: begin
        if (bus.nMREQ) begin
          ncs_d   = 1'b1;
          noe_d   = 1'b1;
          doe_d   = 1'b0;
          state_d = IDLE;
        end
      end

      WR_SETUP: begin
        if (bus.nMREQ) begin
          ncs_d   = 1'b1;
          noe_d   = 1'b1;
          nwe_d   = 1'b1;
          wdrv_d  = 1'b0;
          nwait_d = 1'b1;
          doe_d   = 1'b0;
          state_d = IDLE;
        end else begin
          nwe_d   = 1'b0;
          cnt_d   = WAIT_WR_C;
          state_d = WR_PULSE;
        end
      end

      WR_PULSE: begin
        // An abort mid-pulse still ends the pulse cleanly and keeps the data held.
        if (bus.nMREQ || (cnt_q == 4'd0)) begin
          nwe_d   = 1'b1;
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      WR_HOLD: begin
        nwait_d = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        if (bus.nMREQ) begin
          ncs_d   = 1'b1;
          wdrv_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ram_a_q <= 16'h0000;
      wdata_q <= 8'h00;
      wdrv_q  <= 1'b0;
      ncs_q   <= 1'b1;
      noe_q   <= 1'b1;
      nwe_q   <= 1'b1;
      nwait_q <= 1'b1;
      dout_q  <= 8'h00;
      doe_q   <= 1'b0;
      err_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ram_a_q <= ram_a_d;
      wdata_q <= wdata_d;
      wdrv_q  <= wdrv_d;
      ncs_q   <= ncs_d;
      noe_q   <= noe_d;
      nwe_q   <= nwe_d;
      nwait_q <= nwait_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
      err_q   <= err_d;
    end
  end

  assign ram_D = wdrv_q ? wdata_q : 8'hzz;

  assign bus.ram_A   = ram_a_q;
  assign bus.ram_nCS = ncs_q;
  assign bus.ram_nOE = noe_q;
  assign bus.ram_nWE = nwe_q;
  assign bus.nWAIT   = nwait_q;
  assign bus.D_out   = dout_q;
  assign bus.D_oe    = doe_q;
  assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_z80_mem_ctl.sv
// Bench for z80_mem_ctl: directed protocol cases plus random reads/writes checked
// against a flat memory model and cycle counts derived from the wait parameters.
`timescale 1ns/1ps
module tb_z80_mem_ctl;

  localparam int unsigned WRD = 2;
  localparam int unsigned WWR = 1;

  logic      CLK;
  logic      nRESET;
  wire [7:0] ram_D;

  z80_mem_ctl_if bus_if ();

  z80_mem_ctl #(.WAIT_RD(WRD), .WAIT_WR(WWR)) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus_if),
    .ram_D  (ram_D)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Asynchronous SRAM: drives while selected and output-enabled, captures on nWE rise.
  logic [7:0] ram_mem [0:65535];
  assign ram_D = (!bus_if.ram_nCS && !bus_if.ram_nOE) ? ram_mem[bus_if.ram_A] : 8'hzz;
  always @(posedge bus_if.ram_nWE) begin
    if (!bus_if.ram_nCS && nRESET) ram_mem[bus_if.ram_A] = ram_D;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: every byte starts at a known pattern; completed writes overwrite it.
  logic [7:0] ref_mem [logic [15:0]];
  logic [7:0] exp_dout;
  logic [15:0] wq [$];

  function automatic logic [7:0] init_pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_pat(a);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    bus_if.nMREQ = 1'b1;
    bus_if.nRD   = 1'b1;
    bus_if.nWR   = 1'b1;
    bus_if.nRFSH = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] addr, input string tag);
    int waits;
    logic [7:0] exp;
    exp = ref_read(addr);
    bus_if.A     = addr;
    bus_if.nMREQ = 1'b0;
    bus_if.nRD   = 1'b0;
    tick();
    chk({tag, "_e0"}, {bus_if.ram_A, bus_if.ram_nCS, bus_if.ram_nOE, bus_if.ram_nWE}, {addr, 3'b001});
    waits = 0;
    while (bus_if.nWAIT == 1'b0 && waits < 40) begin
      waits++;
      tick();
    end
    chk({tag, "_nwait_cycles"}, waits, WRD + 1);
    chk({tag, "_dout"}, {bus_if.D_out, bus_if.D_oe, bus_if.ram_nOE}, {exp, 2'b10});
    bus_if.nMREQ = 1'b1;
    bus_if.nRD   = 1'b1;
    tick();
    chk({tag, "_release"}, {bus_if.ram_nCS, bus_if.ram_nOE, bus_if.D_oe, bus_if.D_out}, {3'b110, exp});
    exp_dout = exp;
    $display("%0t %s read  addr=%h data=%h nwait_low=%0d", $time, tag, addr, bus_if.D_out, waits);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input string tag);
    int waits;
    int nwe_low;
    bus_if.A     = addr;
    bus_if.D_in  = data;
    bus_if.nMREQ = 1'b0;
    bus_if.nWR   = 1'b0;
    tick();
    chk({tag, "_e0"}, {bus_if.ram_A, bus_if.ram_nCS, bus_if.ram_nOE, bus_if.ram_nWE, bus_if.nWAIT},
        {addr, 4'b0110});
    chk({tag, "_data_e0"}, ram_D, data);
    waits   = 0;
    nwe_low = 0;
    while (bus_if.nWAIT == 1'b0 && waits < 40) begin
      waits++;
      tick();
      if (!bus_if.ram_nWE) nwe_low++;
    end
    chk({tag, "_nwait_cycles"}, waits, WWR + 3);
    chk({tag, "_nwe_cycles"}, nwe_low, WWR + 1);
    chk({tag, "_done_hold"}, {bus_if.ram_nCS, bus_if.ram_nWE, ram_D}, {2'b01, data});
    bus_if.nMREQ = 1'b1;
    bus_if.nWR   = 1'b1;
    tick();
    chk({tag, "_release"}, {bus_if.ram_nCS, bus_if.ram_nWE, bus_if.ram_nOE}, 3'b111);
    ref_mem[addr] = data;
    wq.push_back(addr);
    $display("%0t %s write addr=%h data=%h nwait_low=%0d nwe_low=%0d", $time, tag, addr, data, waits, nwe_low);
  endtask

  // Continuous protocol monitor: strobe exclusion and address/data stability around nWE.
  logic [15:0] mon_a_prev;
  logic [7:0]  mon_d_prev;
  logic        mon_nwe_prev = 1'b1;
  logic        mon_rst_prev = 1'b0;
  always @(negedge CLK) begin
    chk("oe_we_exclusive", {31'd0, bus_if.ram_nOE | bus_if.ram_nWE}, 32'd1);
    if (nRESET && mon_rst_prev && (!bus_if.ram_nWE || !mon_nwe_prev))
      chk("nwe_addr_data_stable", {bus_if.ram_A, ram_D}, {mon_a_prev, mon_d_prev});
    mon_a_prev   = bus_if.ram_A;
    mon_d_prev   = ram_D;
    mon_nwe_prev = bus_if.ram_nWE;
    mon_rst_prev = nRESET;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] addr;
    logic [7:0]  data;
    logic        saw_cs;

    for (int i = 0; i < 65536; i++) ram_mem[i] = init_pat(16'(i));
    ram_mem[16'h0100] = 8'h3E;
    ref_mem[16'h0100] = 8'h3E;
    exp_dout = 8'h00;

    nRESET = 1'b0;
    bus_idle();
    bus_if.A    = 16'h0000;
    bus_if.D_in = 8'h00;

    // Reset held with random bus activity.
    for (int i = 0; i < 6; i++) begin
      bus_if.A     = 16'($urandom);
      bus_if.D_in  = 8'($urandom);
      bus_if.nMREQ = 1'($urandom);
      bus_if.nRD   = 1'($urandom);
      bus_if.nWR   = 1'($urandom);
      bus_if.nRFSH = 1'($urandom);
      tick();
      chk("rst_strobes", {bus_if.ram_nCS, bus_if.ram_nOE, bus_if.ram_nWE, bus_if.nWAIT, bus_if.D_oe}, 5'b11110);
      chk("rst_values", {bus_if.ram_A, bus_if.D_out, bus_if.err_cnt}, 32'h0);
    end
    bus_idle();
    nRESET = 1'b1;
    tick();

    do_read(16'h0100, "dir_rd");
    do_write(16'h8000, 8'hA5, "dir_wr");
    do_read(16'h8000, "dir_rdback");

    // Refresh and strobe-less cycles never touch the RAM.
    bus_if.nMREQ = 1'b0;
    bus_if.nRFSH = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_if.nRD = (i == 2) ? 1'b0 : 1'b1;
      bus_if.nWR = (i == 3) ? 1'b0 : 1'b1;
      tick();
      chk("rfsh_no_access", {bus_if.ram_nCS, bus_if.ram_nOE, bus_if.ram_nWE, bus_if.nWAIT}, 4'b1111);
    end
    bus_if.nRFSH = 1'b1;
    bus_if.nRD   = 1'b1;
    bus_if.nWR   = 1'b1;
    tick();
    chk("nostrobe_no_access", {bus_if.ram_nCS, bus_if.nWAIT, bus_if.err_cnt}, {2'b11, 8'd0});
    bus_idle();
    tick();

    // Protocol errors: both strobes low, 260 pulses, count saturates.
    saw_cs = 1'b0;
    for (int i = 1; i <= 260; i++) begin
      bus_if.nMREQ = 1'b0;
      bus_if.nRD   = 1'b0;
      bus_if.nWR   = 1'b0;
      tick();
      if (!bus_if.ram_nCS) saw_cs = 1'b1;
      bus_idle();
      tick();
      if (i == 10) chk("err_cnt_10", bus_if.err_cnt, 8'd10);
    end
    chk("err_cnt_sat", bus_if.err_cnt, 8'd255);
    chk("err_no_access", {31'd0, saw_cs}, 32'd0);
    $display("%0t protocol-error pulses=260 err_cnt=%0d", $time, bus_if.err_cnt);

    // Abort a write during the nWE pulse.
    bus_if.A     = 16'h4444;
    bus_if.D_in  = 8'h77;
    bus_if.nMREQ = 1'b0;
    bus_if.nWR   = 1'b0;
    tick();
    tick();
    chk("abwr_pulse", {bus_if.ram_nWE, bus_if.ram_nCS}, 2'b00);
    bus_idle();
    tick();
    chk("abwr_nwe_up", {bus_if.ram_nWE, bus_if.ram_nCS, ram_D}, {2'b10, 8'h77});
    tick();
    chk("abwr_hold", {bus_if.nWAIT, bus_if.ram_nCS, ram_D}, {2'b10, 8'h77});
    tick();
    chk("abwr_idle", {bus_if.ram_nCS, bus_if.ram_nWE}, 2'b11);
    ref_mem[16'h4444] = 8'h77;
    $display("%0t abort write addr=4444 data=77", $time);
    do_read(16'h4444, "abwr_rdback");

    // Abort a read during the access wait.
    bus_if.A     = 16'h0100;
    bus_if.nMREQ = 1'b0;
    bus_if.nRD   = 1'b0;
    tick();
    chk("abrd_acc", {bus_if.ram_nOE, bus_if.nWAIT}, 2'b00);
    bus_idle();
    tick();
    chk("abrd_idle", {bus_if.ram_nCS, bus_if.ram_nOE, bus_if.nWAIT, bus_if.D_oe, bus_if.D_out},
        {4'b1110, exp_dout});
    $display("%0t abort read addr=0100", $time);
    do_read(16'h0100, "abrd_next");

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      addr = 16'($urandom);
      data = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_write(addr, data, "rnd");
      end else begin
        if (wq.size() > 0 && $urandom_range(0, 1) == 1) addr = wq[$urandom_range(0, wq.size() - 1)];
        do_read(addr, "rnd");
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    // Asynchronous reset in the middle of the nWE pulse.
    bus_if.A     = 16'hF0F0;
    bus_if.D_in  = 8'hC3;
    bus_if.nMREQ = 1'b0;
    bus_if.nWR   = 1'b0;
    tick();
    tick();
    chk("arst_pre", {bus_if.ram_nWE, bus_if.ram_nCS}, 2'b00);
    #2;
    nRESET = 1'b0;
    #1;
    chk("arst_strobes", {bus_if.ram_nWE, bus_if.ram_nCS, bus_if.ram_nOE, bus_if.nWAIT, bus_if.D_oe}, 5'b11110);
    chk("arst_values", {bus_if.ram_A, bus_if.D_out, bus_if.err_cnt}, 32'h0);
    exp_dout = 8'h00;
    $display("%0t async reset during write pulse", $time);
    bus_idle();
    tick();
    nRESET = 1'b1;
    tick();
    do_read(16'hF0F0, "arst_rd");
    do_read(16'h0100, "arst_rd2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
